multiplier_job_sequencer: RTL and testbench
===========================================

Name: multiplier_job_sequencer

Overview:
- Issue/collect stage wrapped around the constant-time multiplier (datapath + control).
- Upstream: accepts operand pairs over a valid/ready handshake, latches them, pulses the multiplier's start and holds the operands stable while the job runs.
- Downstream: captures the product when the multiplier signals done, measures job latency, and buffers results in a small FIFO for a valid/ready consumer.
- A watchdog flags jobs that exceed the expected constant-time bound.

Parameters:
- WIDTH, 10000, operand width; product is 2*WIDTH.
- MAX_CYCLES, 40016, watchdog limit in cycles per job.
- OUT_DEPTH, 2, result FIFO depth (≥1).
- CW, $clog2(MAX_CYCLES+1), cycle-count width (derived).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_multiplier  in  WIDTH  multiplier operand.
- in_multiplicand  in  WIDTH  multiplicand operand.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_multiplier  out  WIDTH  latched operand, held stable for the whole job.
- mul_multiplicand  out  WIDTH  latched operand, held stable for the whole job.
- mul_product  in  2*WIDTH  multiplier product.
- mul_done  in  1  multiplier productDone.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops the head when out_valid && out_ready.
- out_product  out  2*WIDTH  FIFO head product.
- out_cycles  out  CW  FIFO head job latency.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; FIFO is emptied.
  - mul_start=0, mul_multiplier=0, mul_multiplicand=0, out_valid=0, out_product=0, out_cycles=0, timeout_err=0, cycle counter=0.
  - Reset mid-job abandons the job; nothing is pushed to the FIFO.
- States: IDLE, START, WAIT_LOW, WAIT_HIGH.
- in_ready = (state==IDLE) && (fifo_count < OUT_DEPTH). It is combinational from registered state only and never depends on in_valid.
- IDLE: on accept, latch both operands into mul_multiplier and mul_multiplicand, clear the counter, go to START.
- START: mul_start=1 for exactly this cycle; counter=1; go to WAIT_LOW.
- WAIT_LOW:
  - Ignore mul_done until it is sampled low at least once. This rejects a stale done level left over from the previous job.
  - Counter increments each cycle.
  - On mul_done==0, go to WAIT_HIGH.
- WAIT_HIGH:
  - Counter increments each cycle.
  - On mul_done==1, push {mul_product, counter} into the FIFO and go to IDLE. Space is guaranteed by the accept rule.
  - out_cycles is the count of cycles from the mul_start cycle (=1) through the done-sample cycle, inclusive.
- Watchdog:
  - Applies in WAIT_LOW or WAIT_HIGH when the counter reaches MAX_CYCLES with no qualifying done.
  - timeout_err is set (sticky until reset), nothing is pushed, and the state returns to IDLE.
  - The counter saturates and never wraps.
- mul_start is never asserted outside START; back-to-back jobs need at least one IDLE cycle between them.
- FIFO:
  - out_valid = (count != 0); out_product and out_cycles show the head entry.
  - Push and pop in the same cycle is legal: count is unchanged, and the head advances correctly even when count==1.
  - The read and write pointers wrap modulo OUT_DEPTH.
  - A full FIFO holds in_ready low. Any job already in flight still has its slot reserved.
- The block does no arithmetic on the product; it passes through bit-exact.

Decomposition:
- Shared package:
  - State encoding enum (IDLE, START, WAIT_LOW, WAIT_HIGH).
  - Helper for the CW derivation.
  - MAX_CYCLES default expression (4*WIDTH+16).
- One natural sub-module, result_fifo:
  - Parameters: data width 2*WIDTH+CW, OUT_DEPTH.
  - Ports: push, pop, full, count, head data.
  - Same clk and active-low async rst.

Test Plan (WIDTH=8, MAX_CYCLES=40, OUT_DEPTH=2, behavioural multiplier stub asserting done N cycles after start):
- Reset then single job 13×11, stub N=20, out_ready=1 -> one mul_start pulse; operands held at 13/11 until IDLE; out_product=143, out_cycles=21, timeout_err=0.
- Stale done: stub holds mul_done=1 from a prior job for 3 cycles after the new start, then low, then high -> no early capture; product is taken only on the second rising level.
- Backpressure: out_ready=0, issue 255×255 then 2×3 -> both complete; a third in_valid sees in_ready=0; raise out_ready -> pops 65025 then 6 in order.
- Simultaneous push/pop with count==1 -> count stays 1 and the head shows the new entry the next cycle.
- Timeout: stub never asserts done -> after 40 cycles timeout_err=1 (sticky), nothing is pushed, in_ready returns 1, and the next normal job still completes correctly.
- Async reset asserted mid-WAIT_HIGH -> outputs zero immediately without a clock edge; after release the FIFO is empty and the next job 7×9 returns 63.

Source files
------------

// File: rtl/multiplier_job_sequencer_pkg.sv
// Shared types and parameter helpers for the multiplier job sequencer.
package multiplier_job_sequencer_pkg;

  // Sequencer states: wait for a job, pulse start, then wait for the done
  // level to drop (stale level from the previous job) and rise again.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } seq_state_t;

  // Constant-time bound of the multiplier plus some margin.
  function automatic int max_cycles_for(input int width);
    return 4 * width + 16;
  endfunction

  // Width needed to hold a cycle count from 0 up to max_cycles.
  function automatic int count_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/multiplier_job_sequencer_result_fifo.sv
// Small result FIFO; the head entry is always visible on head.
module result_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   push_data,
  output logic            full,
  output logic [CNTW-1:0] count,
  output logic [DW-1:0]   head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNTW'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage and pointers; a push into a slot being popped is fine because
  // the read side moves on to the next entry in the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multiplier_job_sequencer.sv
// Issue/collect stage around the constant-time multiplier: accepts operand
// pairs, runs one job at a time, times it, and queues product plus latency.
module multiplier_job_sequencer
  import multiplier_job_sequencer_pkg::*;
#(
  parameter int WIDTH      = 10000,
  parameter int MAX_CYCLES = max_cycles_for(WIDTH),
  parameter int OUT_DEPTH  = 2,
  parameter int CW         = count_width(MAX_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [WIDTH-1:0]   in_multiplicand,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [CW-1:0]      out_cycles,
  output logic               timeout_err
);

  localparam int DW  = 2 * WIDTH + CW;
  localparam int FCW = $clog2(OUT_DEPTH + 1);

  seq_state_t     state;
  seq_state_t     state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  job_cycles;
  logic           accept;
  logic           push;
  logic           pop;
  logic           timeout_hit;
  logic           fifo_full;
  logic [FCW-1:0] fifo_count;
  logic [DW-1:0]  push_data;
  logic [DW-1:0]  head_data;

  // cnt holds the cycles already elapsed in the job; job_cycles counts the
  // current cycle too, so the start cycle reads as 1.
  assign job_cycles = cnt + CW'(1);

  // A full FIFO blocks new jobs, so an in-flight job always has a slot.
  assign in_ready  = (state == IDLE) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign mul_start = (state == START);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push_data = {mul_product, job_cycles};

  assign out_product = head_data[DW-1:CW];
  assign out_cycles  = head_data[CW-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state, result push and watchdog trip; a done that is still high
  // from the previous job only counts after it has been seen low once.
  always_comb begin
    state_next  = state;
    push        = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (job_cycles == CW'(MAX_CYCLES)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else if (!mul_done) begin
          state_next = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (mul_done) begin
          push       = 1'b1;
          state_next = IDLE;
        end else if (job_cycles == CW'(MAX_CYCLES)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, saturating job counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      cnt              <= '0;
      timeout_err      <= 1'b0;
    end else begin
      if (accept) begin
        mul_multiplier   <= in_multiplier;
        mul_multiplicand <= in_multiplicand;
      end
      if (timeout_hit) timeout_err <= 1'b1;
      case (state)
        IDLE:    cnt <= '0;
        START:   cnt <= CW'(1);
        default: if (cnt != CW'(MAX_CYCLES)) cnt <= job_cycles;
      endcase
    end
  end

  result_fifo #(
    .DW    (DW),
    .DEPTH (OUT_DEPTH),
    .CNTW  (FCW)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .full      (fifo_full),
    .count     (fifo_count),
    .head      (head_data)
  );

endmodule

// File: tb/tb_multiplier_job_sequencer.sv
// Directed bench for multiplier_job_sequencer with a behavioural multiplier
// stub whose done timing and stale-done behaviour are set per job.
module tb_multiplier_job_sequencer;

  localparam int WIDTH      = 8;
  localparam int MAX_CYCLES = 40;
  localparam int OUT_DEPTH  = 2;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_multiplier;
  logic [WIDTH-1:0]   in_multiplicand;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_multiplier;
  logic [WIDTH-1:0]   mul_multiplicand;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_done;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [CW-1:0]      out_cycles;
  logic               timeout_err;

  int compared    = 0;
  int mismatched  = 0;
  int start_pulses = 0;

  // Stub control: done rises stub_n cycles after the start cycle, optionally
  // holds a stale high level for stub_stale cycles after start, or never rises.
  int since      = 0;
  int stub_n     = 20;
  int stub_stale = 0;
  bit stub_never = 1'b0;
  logic stale_level;
  logic ready_level;

  multiplier_job_sequencer #(
    .WIDTH      (WIDTH),
    .MAX_CYCLES (MAX_CYCLES),
    .OUT_DEPTH  (OUT_DEPTH),
    .CW         (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_cycles       (out_cycles),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // since is the cycle number within the current job (start cycle = 1).
  always @(posedge clk) begin
    if (mul_start) since <= 2;
    else if (since != 0 && since < 1000) since <= since + 1;
  end

  // Stub outputs; the product is garbage until the real done level arrives.
  always_comb begin
    stale_level = (since >= 2) && (since <= 1 + stub_stale);
    ready_level = !stub_never && (since >= stub_n + 1);
    mul_done    = stale_level || ready_level;
    mul_product = ready_level ? ({8'h00, mul_multiplier} * {8'h00, mul_multiplicand})
                              : 16'hdead;
  end

  // Count every start pulse the DUT issues.
  always @(posedge clk) begin
    if (mul_start) start_pulses <= start_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one operand pair and return at the negedge of the START cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    in_multiplier   = a;
    in_multiplicand = b;
    in_valid        = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_wait", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int pulses_before;
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_multiplier   = '0;
    in_multiplicand = '0;
    out_ready       = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_a", mul_multiplier, 0);
    checkOutput("rst_mul_b", mul_multiplicand, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_product", out_product, 0);
    checkOutput("rst_out_cycles", out_cycles, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    advance(1);
    checkOutput("rst_in_ready", in_ready, 1);

    // Single job 13x11, done 20 cycles after start
    stub_n = 20; stub_stale = 0; stub_never = 1'b0;
    applyStimulus(8'd13, 8'd11);
    checkOutput("t1_start", mul_start, 1);
    checkOutput("t1_op_a", mul_multiplier, 13);
    checkOutput("t1_op_b", mul_multiplicand, 11);
    advance(20);
    checkOutput("t1_held_a", mul_multiplier, 13);
    checkOutput("t1_held_b", mul_multiplicand, 11);
    checkOutput("t1_start_low", mul_start, 0);
    checkOutput("t1_not_yet", out_valid, 0);
    advance(1);
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_product", out_product, 143);
    checkOutput("t1_cycles", out_cycles, 21);
    checkOutput("t1_timeout", timeout_err, 0);
    checkOutput("t1_pulses", start_pulses, 1);
    checkOutput("t1_in_ready", in_ready, 1);
    advance(1);
    checkOutput("t1_popped", out_valid, 0);

    // Stale done high for 3 cycles after start must not be captured
    out_ready = 1'b0;
    stub_n = 9; stub_stale = 3;
    applyStimulus(8'd5, 8'd6);
    advance(4);
    checkOutput("t2_no_early", out_valid, 0);
    advance(6);
    checkOutput("t2_valid", out_valid, 1);
    checkOutput("t2_product", out_product, 30);
    checkOutput("t2_cycles", out_cycles, 10);
    out_ready = 1'b1;
    advance(1);
    checkOutput("t2_popped", out_valid, 0);
    stub_stale = 0;

    // Backpressure: two results queue up, third request is held off
    out_ready = 1'b0;
    stub_n = 20;
    applyStimulus(8'd255, 8'd255);
    advance(21);
    checkOutput("t3_first_valid", out_valid, 1);
    stub_n = 4;
    applyStimulus(8'd2, 8'd3);
    advance(5);
    checkOutput("t3_full_ready", in_ready, 0);
    pulses_before = start_pulses;
    in_multiplier = 8'd1; in_multiplicand = 8'd1; in_valid = 1'b1;
    advance(3);
    checkOutput("t3_held_ready", in_ready, 0);
    checkOutput("t3_no_start", start_pulses, pulses_before);
    in_valid = 1'b0;
    checkOutput("t3_head1_product", out_product, 65025);
    checkOutput("t3_head1_cycles", out_cycles, 21);
    out_ready = 1'b1;
    advance(1);
    checkOutput("t3_head2_valid", out_valid, 1);
    checkOutput("t3_head2_product", out_product, 6);
    checkOutput("t3_head2_cycles", out_cycles, 5);
    advance(1);
    checkOutput("t3_drained", out_valid, 0);

    // Push and pop in the same cycle with one entry queued
    out_ready = 1'b0;
    stub_n = 5;
    applyStimulus(8'd3, 8'd4);
    advance(6);
    checkOutput("t4_first_valid", out_valid, 1);
    checkOutput("t4_first_product", out_product, 12);
    stub_n = 6;
    applyStimulus(8'd10, 8'd10);
    advance(6);
    checkOutput("t4_head_before", out_product, 12);
    out_ready = 1'b1;
    advance(1);
    out_ready = 1'b0;
    checkOutput("t4_count_one", out_valid, 1);
    checkOutput("t4_new_product", out_product, 100);
    checkOutput("t4_new_cycles", out_cycles, 7);
    out_ready = 1'b1;
    advance(1);
    checkOutput("t4_empty", out_valid, 0);

    // Watchdog: done never rises
    stub_never = 1'b1;
    applyStimulus(8'd9, 8'd9);
    advance(39);
    checkOutput("t5_not_early", timeout_err, 0);
    advance(1);
    checkOutput("t5_timeout", timeout_err, 1);
    checkOutput("t5_in_ready", in_ready, 1);
    checkOutput("t5_no_push", out_valid, 0);
    stub_never = 1'b0;
    stub_n = 3;
    applyStimulus(8'd4, 8'd5);
    advance(4);
    checkOutput("t5_next_valid", out_valid, 1);
    checkOutput("t5_next_product", out_product, 20);
    checkOutput("t5_next_cycles", out_cycles, 4);
    checkOutput("t5_sticky", timeout_err, 1);
    advance(1);

    // Asynchronous reset in the middle of WAIT_HIGH
    stub_n = 20;
    applyStimulus(8'd7, 8'd7);
    advance(9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_a", mul_multiplier, 0);
    checkOutput("t6_rst_b", mul_multiplicand, 0);
    checkOutput("t6_rst_timeout", timeout_err, 0);
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_product", out_product, 0);
    checkOutput("t6_rst_cycles", out_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    advance(11);
    checkOutput("t6_abandoned", out_valid, 0);
    stub_n = 4;
    applyStimulus(8'd7, 8'd9);
    advance(5);
    checkOutput("t6_valid", out_valid, 1);
    checkOutput("t6_product", out_product, 63);
    checkOutput("t6_cycles", out_cycles, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
